result_bus_arbiter: RTL

RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

---
 rtl/result_bus_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/result_bus_arbiter.sv
// rtl/result_bus_arbiter.sv - round-robin result bus arbiter with per-requester flushable FIFOs
// Optional macro RBA_CONFLICT_CNT_EN adds OUT_conflictCnt (cycles with two or more live heads).
module result_bus_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       IN_valid [NUM_REQ],
   input  logic [31:0]                IN_result [NUM_REQ],
   input  logic [5:0]                 IN_tagDst [NUM_REQ],
   input  logic [4:0]                 IN_nmDst [NUM_REQ],
   input  logic [5:0]                 IN_sqN [NUM_REQ],
   output logic                       OUT_ready [NUM_REQ],
   input  logic                       IN_invalidate,
   input  logic [5:0]                 IN_invalidateSqN,
   output logic                       OUT_valid,
   output logic [31:0]                OUT_result,
   output logic [5:0]                 OUT_tagDst,
   output logic [4:0]                 OUT_nmDst,
   output logic [5:0]                 OUT_sqN,
   output logic [$clog2(NUM_REQ)-1:0] OUT_reqIdx
`ifdef RBA_CONFLICT_CNT_EN
   ,
   output logic [31:0]                OUT_conflictCnt
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [PW:0] DEPTH_V = FIFO_DEPTH[PW:0];
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   logic [31:0]   mem_result [NUM_REQ][FIFO_DEPTH];
   logic [5:0]    mem_tag    [NUM_REQ][FIFO_DEPTH];
   logic [4:0]    mem_nm     [NUM_REQ][FIFO_DEPTH];
   logic [5:0]    mem_sqn    [NUM_REQ][FIFO_DEPTH];
   logic          mem_live   [NUM_REQ][FIFO_DEPTH];
   logic [PW:0]   wptr [NUM_REQ];
   logic [PW:0]   rptr [NUM_REQ];
   logic [IW-1:0] last_grant;

   logic [PW:0]   occ [NUM_REQ];
   logic [PW-1:0] head [NUM_REQ];
   logic          head_live [NUM_REQ];
   logic          head_ok [NUM_REQ];
   logic          push [NUM_REQ];
   logic          pop [NUM_REQ];
   logic          grant_any;
   logic [IW-1:0] grant_idx;
   logic [IW-1:0] scan_idx;

   // 6-bit wrap-around age compare: true when s is strictly younger than base
   function automatic logic younger(input logic [5:0] s, input logic [5:0] base);
      logic [5:0] d;
      d = s - base;
      return !d[5] && (d != 6'd0);
   endfunction

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         occ[i]       = wptr[i] - rptr[i];
         head[i]      = rptr[i][PW-1:0];
         OUT_ready[i] = (occ[i] < DEPTH_V);
         head_live[i] = (occ[i] != '0) && mem_live[i][head[i]];
         head_ok[i]   = head_live[i] &&
                        !(IN_invalidate && younger(mem_sqn[i][head[i]], IN_invalidateSqN));
         push[i]      = IN_valid[i] && OUT_ready[i];
      end
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IW'((int'(last_grant) + k) % NUM_REQ);
         if (!grant_any && head_ok[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
      // killed heads (stored or killed this cycle) drain without using the bus
      for (int i = 0; i < NUM_REQ; i++)
         pop[i] = (occ[i] != '0) && (!head_ok[i] || (grant_any && grant_idx == IW'(i)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            wptr[i] <= '0;
            rptr[i] <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++)
               mem_live[i][j] <= 1'b0;
         end
         last_grant <= IW'(NUM_REQ - 1);
         OUT_valid  <= 1'b0;
         OUT_reqIdx <= '0;
         OUT_result <= '0;
         OUT_tagDst <= '0;
         OUT_nmDst  <= '0;
         OUT_sqN    <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < FIFO_DEPTH; j++)
               if (IN_invalidate && younger(mem_sqn[i][j], IN_invalidateSqN))
                  mem_live[i][j] <= 1'b0;
            if (push[i]) begin
               mem_live[i][wptr[i][PW-1:0]] <=
                  !(IN_invalidate && younger(IN_sqN[i], IN_invalidateSqN));
               wptr[i] <= wptr[i] + PTR_ONE;
            end
            if (pop[i])
               rptr[i] <= rptr[i] + PTR_ONE;
         end
         OUT_valid <= grant_any;
         if (grant_any) begin
            last_grant <= grant_idx;
            OUT_reqIdx <= grant_idx;
            OUT_result <= mem_result[grant_idx][head[grant_idx]];
            OUT_tagDst <= mem_tag[grant_idx][head[grant_idx]];
            OUT_nmDst  <= mem_nm[grant_idx][head[grant_idx]];
            OUT_sqN    <= mem_sqn[grant_idx][head[grant_idx]];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (push[i]) begin
            mem_result[i][wptr[i][PW-1:0]] <= IN_result[i];
            mem_tag[i][wptr[i][PW-1:0]]    <= IN_tagDst[i];
            mem_nm[i][wptr[i][PW-1:0]]     <= IN_nmDst[i];
            mem_sqn[i][wptr[i][PW-1:0]]    <= IN_sqN[i];
         end
      end
   end

`ifdef RBA_CONFLICT_CNT_EN
   int live_heads;

   always_comb begin
      live_heads = 0;
      for (int i = 0; i < NUM_REQ; i++)
         if (head_live[i]) live_heads++;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         OUT_conflictCnt <= '0;
      else if (live_heads >= 2 && OUT_conflictCnt != 32'hFFFF_FFFF)
         OUT_conflictCnt <= OUT_conflictCnt + 32'd1;
   end
`endif
endmodule
